sine_rx_meter: RTL

- Receive-side counterpart of the 10-bit parallel sine DAC output path.
- Samples a 10-bit parallel word from an external ADC, or from the DAC pins in loopback.
- Detects rising midpoint crossings with hysteresis and measures each cycle's period (in samples), peak and trough.
- Reports a lock flag when successive periods agree; used for bench/board self-check of the sine generator.

---
 rtl/sine_rx_meter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sine_rx_meter.sv
// ---------------------------------------------------------------------------
// sine_rx_meter
//
// Receive-side meter for the 10-bit parallel sine path. Takes offset-binary
// samples from an external ADC (or the DAC pins in loopback). Rising midpoint
// crossings are detected with hysteresis. For every full cycle the meter
// reports the period (in valid samples), the peak and the trough. It also
// raises a lock flag when successive periods agree.
//
// Handshake: sample_valid qualifies sample_in in the same cycle. There is no
// backpressure; cycles with sample_valid=0 are ignored entirely. meas_valid
// is a one-clock strobe marking that period/peak/trough/locked were just
// updated. Those outputs hold their values between strobes.
//
// Optional build macro: SINE_RX_SYNC_EN
//   When defined, sample_in/sample_valid pass through a 2-flop synchronizer
//   ahead of the capture register. This supports asynchronous ADCs and adds
//   2 clk to every latency.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_in    parallel sample word (DATA_W)
//   sample_valid sample_in valid this cycle
//   period       last measured period in valid samples (PERIOD_W, saturating)
//   peak         max sample over last measured cycle
//   trough       min sample over last measured cycle
//   meas_valid   one-clk pulse: measurement outputs updated
//   locked       last two periods unsaturated and within LOCK_TOL
//   fsm_state    debug view of the crossing FSM (0=INIT, 1=LOW, 2=HIGH)
// ---------------------------------------------------------------------------
module sine_rx_meter #(
  parameter int DATA_W   = 10,
  parameter int PERIOD_W = 16,
  parameter int HYST     = 8,
  parameter int LOCK_TOL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [DATA_W-1:0]   peak,
  output logic [DATA_W-1:0]   trough,
  output logic                meas_valid,
  output logic                locked,
  output logic [1:0]          fsm_state
);

  localparam int                  MID_I   = 1 << (DATA_W - 1);
  localparam logic [DATA_W-1:0]   HI      = DATA_W'(MID_I + HYST);
  localparam logic [DATA_W-1:0]   LO      = DATA_W'(MID_I - HYST);
  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] TOL     = PERIOD_W'(LOCK_TOL);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // ---------------- input stage ----------------
  logic [DATA_W-1:0] in_data;
  logic              in_vld;

`ifdef SINE_RX_SYNC_EN
  logic [DATA_W-1:0] sync_d1, sync_d2;
  logic              sync_v1, sync_v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d1 <= '0;
      sync_d2 <= '0;
      sync_v1 <= 1'b0;
      sync_v2 <= 1'b0;
    end else begin
      sync_d1 <= sample_in;
      sync_d2 <= sync_d1;
      sync_v1 <= sample_valid;
      sync_v2 <= sync_v1;
    end
  end

  assign in_data = sync_d2;
  assign in_vld  = sync_v2;
`else
  assign in_data = sample_in;
  assign in_vld  = sample_valid;
`endif

  logic [DATA_W-1:0] s_reg;
  logic              v_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= '0;
      v_reg <= 1'b0;
    end else begin
      v_reg <= in_vld;
      if (in_vld) s_reg <= in_data;
    end
  end

  // ---------------- crossing FSM ----------------
  state_t state, state_nxt;
  logic   rc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (v_reg) begin
      case (state)
        ST_INIT: begin
          if (s_reg >= HI)      state_nxt = ST_HIGH;
          else if (s_reg <= LO) state_nxt = ST_LOW;
        end
        ST_LOW:  if (s_reg >= HI) state_nxt = ST_HIGH;
        ST_HIGH: if (s_reg <= LO) state_nxt = ST_LOW;
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // Only LOW -> HIGH counts as a rising crossing; leaving INIT does not.
  always_comb begin
    rc = v_reg && (state == ST_LOW) && (s_reg >= HI);
  end

  assign fsm_state = state;

  // ---------------- period / extrema datapath ----------------
  logic [PERIOD_W-1:0] count;
  logic [DATA_W-1:0]   run_max, run_min;
  logic                armed, has_meas;

  logic [PERIOD_W-1:0] count_inc, diff;
  logic [DATA_W-1:0]   pk_new, tr_new;
  logic                lock_new;

  // count_inc doubles as the saturating count+1 reported as period.
  always_comb begin
    count_inc = (count == CNT_MAX) ? count : count + PERIOD_W'(1);
    pk_new    = (s_reg > run_max) ? s_reg : run_max;
    tr_new    = (s_reg < run_min) ? s_reg : run_min;
    diff      = (count_inc >= period) ? (count_inc - period) : (period - count_inc);
    // 'period' still holds the previous measurement here.
    lock_new  = has_meas && (count_inc != CNT_MAX) && (period != CNT_MAX) &&
                (diff <= TOL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      peak       <= '0;
      trough     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      armed      <= 1'b0;
      has_meas   <= 1'b0;
      count      <= '0;
      run_max    <= '0;
      run_min    <= '1;
    end else begin
      meas_valid <= 1'b0;
      if (rc) begin
        // The first crossing after reset starts a cycle but has nothing to report.
        if (armed) begin
          period     <= count_inc;
          peak       <= pk_new;
          trough     <= tr_new;
          locked     <= lock_new;
          meas_valid <= 1'b1;
          has_meas   <= 1'b1;
        end
        count   <= '0;
        run_max <= s_reg;
        run_min <= s_reg;
        armed   <= 1'b1;
      end else if (v_reg) begin
        count   <= count_inc;
        run_max <= pk_new;
        run_min <= tr_new;
      end
    end
  end

endmodule
